fetch_unit: RTL and testbench

Instruction-fetch stage of the RV64 core. It owns the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake with one request outstanding, and hands each returned instruction with its PC to the decode stage through the F/D pipeline register. A one-entry skid buffer absorbs a response that returns while decode is stalled. Branch/jump redirects from execute flush in-flight work. Decode slices `instr_d` into the immediate extender and control decoder.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding req/gnt/rvalid
// handshake to instruction memory and feeds the F/D pipeline register through a one-entry skid.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [63:0] pc_d,
    output logic [63:0] pcplus4_d
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SKID = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state_r;
    logic [63:0] pc_f_r;
    logic [63:0] req_pc_r;
    logic [63:0] skid_pc_r;
    logic [31:0] skid_instr_r;

    logic        fd_free_s;
    logic        load_s;
    logic [31:0] load_instr_s;
    logic [63:0] load_pc_s;

    assign fd_free_s = !valid_d || !stall_d;

    // Request decodes from state and fetch PC only, so no memory input reaches it
    assign imem_req  = (state_r == REQ);
    assign imem_addr = pc_f_r;

    // Select what the F/D register would load this cycle: fresh response or skid contents
    always_comb begin
        load_s       = 1'b0;
        load_instr_s = 32'h0;
        load_pc_s    = 64'h0;
        case (state_r)
            WAIT: begin
                if (imem_rvalid && fd_free_s) begin
                    load_s       = 1'b1;
                    load_instr_s = imem_rdata;
                    load_pc_s    = req_pc_r;
                end else begin
                    load_s = 1'b0;
                end
            end
            SKID: begin
                if (fd_free_s) begin
                    load_s       = 1'b1;
                    load_instr_s = skid_instr_r;
                    load_pc_s    = skid_pc_r;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: load_s = 1'b0;
        endcase
    end

    // Fetch FSM, fetch PC, granted-request PC and skid buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pc_f_r       <= RESET_PC;
            req_pc_r     <= 64'h0;
            skid_pc_r    <= 64'h0;
            skid_instr_r <= 32'h0;
        end else if (redirect) begin
            pc_f_r       <= redirect_pc;
            skid_pc_r    <= 64'h0;
            skid_instr_r <= 32'h0;
            // A request already granted or in flight must have its response swallowed
            case (state_r)
                REQ:        state_r <= imem_gnt ? DROP : REQ;
                WAIT, DROP: state_r <= imem_rvalid ? REQ : DROP;
                default:    state_r <= REQ;
            endcase
        end else begin
            case (state_r)
                IDLE: state_r <= REQ;
                REQ: begin
                    if (imem_gnt) begin
                        req_pc_r <= pc_f_r;
                        pc_f_r   <= pc_f_r + 64'd4;
                        state_r  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (fd_free_s) begin
                            state_r <= REQ;
                        end else begin
                            skid_instr_r <= imem_rdata;
                            skid_pc_r    <= req_pc_r;
                            state_r      <= SKID;
                        end
                    end
                end
                SKID: begin
                    if (fd_free_s) begin
                        state_r <= REQ;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_r <= REQ;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // F/D pipeline register: redirect beats stall, stall holds, otherwise load or bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_d   <= 1'b0;
            instr_d   <= 32'h0;
            pc_d      <= 64'h0;
            pcplus4_d <= 64'h0;
        end else if (redirect) begin
            valid_d <= 1'b0;
        end else if (valid_d && stall_d) begin
            valid_d <= valid_d;
        end else if (load_s) begin
            valid_d   <= 1'b1;
            instr_d   <= load_instr_s;
            pc_d      <= load_pc_s;
            pcplus4_d <= load_pc_s + 64'd4;
        end else begin
            valid_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a one-outstanding memory model feeds a scoreboard
// of {pc, instr} expected at the F/D register; scenario tasks add targeted timing checks.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall_d = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [63:0] pc_d;
    logic [63:0] pcplus4_d;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
        .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t       exp_q[$];
    logic [63:0] addr_log[$];
    int          tests_run = 0;
    int          tests_failed = 0;

    bit          auto_gnt = 1'b0;
    bit          hold_resp = 1'b0;
    bit          use_over = 1'b0;
    logic [31:0] over_data = 32'h0;
    bit          pend = 1'b0;
    bit          pend_stale = 1'b0;
    logic [63:0] pend_addr = 64'h0;
    item_t       cur;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // One clock: drive memory inputs, score the F/D register, advance to the next negedge
    task automatic tick();
        imem_gnt    = imem_req && auto_gnt;
        imem_rvalid = pend && !hold_resp;
        imem_rdata  = imem_rvalid ? (use_over ? over_data : mem_word(pend_addr)) : 32'h0;
        if (valid_d === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard: valid_d with pc_d=%h but nothing expected", pc_d);
            end else begin
                cur = exp_q[0];
                if (pc_d !== cur.pc || instr_d !== cur.instr || pcplus4_d !== cur.pc + 64'd4) begin
                    tests_failed++;
                    $display("FAIL scoreboard: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                             pc_d, instr_d, pcplus4_d, cur.pc, cur.instr, cur.pc + 64'd4);
                end
                if (!stall_d) void'(exp_q.pop_front());
            end
        end
        if (redirect || !rst_n) begin
            exp_q.delete();
            pend_stale = 1'b1;
        end
        if (imem_rvalid) begin
            if (!pend_stale) begin
                cur.pc    = pend_addr;
                cur.instr = imem_rdata;
                exp_q.push_back(cur);
            end
            pend = 1'b0;
        end
        if (imem_gnt) begin
            addr_log.push_back(imem_addr);
            pend       = 1'b1;
            pend_addr  = imem_addr;
            pend_stale = redirect;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        auto_gnt = 1'b0;
        tick();
        tick();
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || valid_d !== 1'b0 || instr_d !== 32'h0 ||
            pc_d !== 64'h0 || pcplus4_d !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_values: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h",
                     imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d);
        end
        rst_n = 1'b1;
        auto_gnt = 1'b1;
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: req=%b expected 0", imem_req); end
        tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            tests_failed++;
            $display("FAIL first_req: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        addr_log.delete();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (imem_rvalid) begin
                tests_run++;
                if (valid_d !== 1'b1 || imem_req !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rvalid_to_valid: valid=%b req=%b expected 1 1", valid_d, imem_req);
                end
            end
        end
        tests_run++;
        if (addr_log.size() != 6) begin
            tests_failed++;
            $display("FAIL throughput: %0d grants in 12 cycles, expected 6", addr_log.size());
        end
        for (int i = 0; i < addr_log.size(); i++) begin
            tests_run++;
            if (addr_log[i] !== RST_PC + 64'(4 * i)) begin
                tests_failed++;
                $display("FAIL addr_seq[%0d]: got %h expected %h", i, addr_log[i], RST_PC + 64'(4 * i));
            end
        end
    endtask

    task automatic test_stall_skid();
        logic [63:0] held_pc;
        for (int i = 0; i < 20 && !(imem_req === 1'b1 && valid_d === 1'b1); i++) tick();
        tests_run++;
        if (imem_req !== 1'b1 || valid_d !== 1'b1) begin
            tests_failed++;
            $display("FAIL skid_setup: req=%b valid=%b expected 1 1", imem_req, valid_d);
        end
        stall_d = 1'b1;
        use_over = 1'b1;
        over_data = 32'h0010_0093;
        tick();
        held_pc = pc_d;
        tick();
        use_over = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (valid_d !== 1'b1 || pc_d !== held_pc || imem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL skid_hold: valid=%b pc=%h req=%b expected 1 %h 0", valid_d, pc_d, imem_req, held_pc);
            end
            tick();
        end
        stall_d = 1'b0;
        tick();
        tests_run++;
        if (valid_d !== 1'b1 || instr_d !== 32'h0010_0093 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL skid_release: valid=%b instr=%h req=%b expected 1 00100093 1", valid_d, instr_d, imem_req);
        end
    endtask

    task automatic test_redirect_wait();
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
        hold_resp = 1'b1;
        tick();
        redirect = 1'b1;
        redirect_pc = 64'h8000_0100;
        tick();
        redirect = 1'b0;
        tests_run++;
        if (valid_d !== 1'b0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_wait_drop: valid=%b req=%b expected 0 0", valid_d, imem_req);
        end
        hold_resp = 1'b0;
        tick();
        tests_run++;
        if (valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_0100) begin
            tests_failed++;
            $display("FAIL redirect_wait_req: valid=%b req=%b addr=%h expected 0 1 8000_0100", valid_d, imem_req, imem_addr);
        end
        for (int i = 0; i < 10 && valid_d !== 1'b1; i++) tick();
        tests_run++;
        if (valid_d !== 1'b1 || pc_d !== 64'h8000_0100) begin
            tests_failed++;
            $display("FAIL redirect_wait_first: valid=%b pc=%h expected 1 8000_0100", valid_d, pc_d);
        end
    endtask

    task automatic test_redirect_gnt();
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
        redirect = 1'b1;
        redirect_pc = 64'h8000_0200;
        tick();
        redirect = 1'b0;
        tests_run++;
        if (valid_d !== 1'b0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_gnt_drop: valid=%b req=%b expected 0 0", valid_d, imem_req);
        end
        tick();
        tests_run++;
        if (valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_0200) begin
            tests_failed++;
            $display("FAIL redirect_gnt_req: valid=%b req=%b addr=%h expected 0 1 8000_0200", valid_d, imem_req, imem_addr);
        end
        for (int i = 0; i < 10 && valid_d !== 1'b1; i++) tick();
        tests_run++;
        if (valid_d !== 1'b1 || pc_d !== 64'h8000_0200) begin
            tests_failed++;
            $display("FAIL redirect_gnt_first: valid=%b pc=%h expected 1 8000_0200", valid_d, pc_d);
        end
    endtask

    task automatic test_redirect_stall();
        for (int i = 0; i < 20 && valid_d !== 1'b1; i++) tick();
        stall_d = 1'b1;
        tick();
        tests_run++;
        if (valid_d !== 1'b1) begin tests_failed++; $display("FAIL stall_hold: valid=%b expected 1", valid_d); end
        redirect = 1'b1;
        redirect_pc = 64'h8000_0300;
        tick();
        redirect = 1'b0;
        stall_d = 1'b0;
        tests_run++;
        if (valid_d !== 1'b0) begin tests_failed++; $display("FAIL redirect_over_stall: valid=%b expected 0", valid_d); end
        for (int i = 0; i < 10 && imem_req !== 1'b1; i++) tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0300) begin
            tests_failed++;
            $display("FAIL redirect_stall_req: req=%b addr=%h expected 1 8000_0300", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 10 && valid_d !== 1'b1; i++) tick();
        tests_run++;
        if (valid_d !== 1'b1 || pc_d !== 64'hFFFF_FFFF_FFFF_FFFC || pcplus4_d !== 64'h0 || imem_addr !== 64'h0) begin
            tests_failed++;
            $display("FAIL wrap: valid=%b pc=%h pc4=%h addr=%h expected 1 fffffffffffffffc 0 0",
                     valid_d, pc_d, pcplus4_d, imem_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
        hold_resp = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || valid_d !== 1'b0 || instr_d !== 32'h0 ||
            pc_d !== 64'h0 || pcplus4_d !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h",
                     imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d);
        end
        rst_n = 1'b1;
        hold_resp = 1'b0;
        tick();
        tests_run++;
        if (valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            tests_failed++;
            $display("FAIL stale_rvalid_ignored: valid=%b req=%b addr=%h expected 0 1 %h", valid_d, imem_req, imem_addr, RST_PC);
        end
        for (int i = 0; i < 10; i++) tick();
        auto_gnt = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (exp_q.size() != 0 || valid_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain: %0d instructions never delivered, valid=%b", exp_q.size(), valid_d);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
